// File: rtl/lsu_pkg.sv
// Shared state encodings, size codes and alignment helper for the LSU AXI-lite master.
package lsu_pkg;

  typedef logic [2:0] lsu_state_e;

  localparam lsu_state_e ST_IDLE    = 3'd0;
  localparam lsu_state_e ST_RD_ADDR = 3'd1;
  localparam lsu_state_e ST_RD_DATA = 3'd2;
  localparam lsu_state_e ST_WR_REQ  = 3'd3;
  localparam lsu_state_e ST_WR_RESP = 3'd4;
  localparam lsu_state_e ST_DONE    = 3'd5;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // The illegal size code is folded in so one test rejects every unissuable request.
  function automatic logic misaligned(input logic [1:0] addr, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = |addr;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobe/replication and load shift/truncate/extend.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_st_strb,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_signed,
  input  logic [31:0] i_ld_data,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;

  always_comb begin
    o_st_data = i_st_data;
    o_st_strb = 4'b1111;
    case (i_st_size)
      SZ_BYTE: begin
        o_st_data = {4{i_st_data[7:0]}};
        o_st_strb = 4'b0001 << i_st_off;
      end
      SZ_HALF: begin
        o_st_data = {2{i_st_data[15:0]}};
        o_st_strb = 4'b0011 << i_st_off;
      end
      default: ;
    endcase
  end

  assign w_shifted = i_ld_data >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld_data = w_shifted;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{i_ld_signed & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_ld_data = {{16{i_ld_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI-lite data-memory master for the core's LSU.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_awvalid,
  input  logic              i_mem_awready,
  output logic [ADDR_W-1:0] o_mem_awaddr,
  output logic              o_mem_wvalid,
  input  logic              i_mem_wready,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [7:0]        o_mem_wstrb,
  input  logic              i_mem_bvalid,
  output logic              o_mem_bready,
  input  logic [1:0]        i_mem_bresp,
  output logic              o_mem_arvalid,
  input  logic              i_mem_arready,
  output logic [ADDR_W-1:0] o_mem_araddr,
  input  logic              i_mem_rvalid,
  output logic              o_mem_rready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [1:0]        i_mem_rresp
);

  lsu_state_e        r_state;
  logic              r_write, r_signed, r_err, r_aw_done, r_w_done;
  logic [1:0]        r_addr_lo, r_size, r_resp;
  logic [DATA_W-1:0] r_rdata, r_wdata;
  logic [ADDR_W-1:0] r_araddr, r_awaddr;
  logic [7:0]        r_wstrb;
  logic              r_arvalid, r_awvalid, r_wvalid, r_rready, r_bready;

  logic              w_misalign, w_aw_fire, w_w_fire, w_timeout, w_tmo_flag;
  logic [31:0]       w_st_data, w_ld_data;
  logic [3:0]        w_st_strb;

  assign w_misalign = misaligned(i_req_addr[1:0], i_req_size);
  assign w_aw_fire  = r_awvalid & i_mem_awready;
  assign w_w_fire   = r_wvalid & i_mem_wready;

  lsu_lane_align u_lane_align (
    .i_st_size   (i_req_size),
    .i_st_off    (i_req_addr[1:0]),
    .i_st_data   (i_req_wdata),
    .o_st_data   (w_st_data),
    .o_st_strb   (w_st_strb),
    .i_ld_size   (r_size),
    .i_ld_off    (r_addr_lo),
    .i_ld_signed (r_signed),
    .i_ld_data   (r_rdata),
    .o_ld_data   (w_ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        r_tmo;
  logic        w_busy;

  assign w_busy = (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA) ||
                  (r_state == ST_WR_REQ)  || (r_state == ST_WR_RESP);
  assign w_timeout  = w_busy && (r_tmo_cnt == 32'(TIMEOUT));
  assign w_tmo_flag = r_tmo;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tmo_cnt <= '0;
      r_tmo     <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (i_req_valid) begin
        r_tmo_cnt <= '0;
        r_tmo     <= 1'b0;
      end
    end else if (w_timeout) begin
      r_tmo <= 1'b1;
    end else if (w_busy) begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end
`else
  assign w_timeout  = 1'b0;
  assign w_tmo_flag = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_write   <= 1'b0;
      r_signed  <= 1'b0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr_lo <= '0;
      r_size    <= '0;
      r_resp    <= RESP_OKAY;
      r_rdata   <= '0;
      r_wdata   <= '0;
      r_araddr  <= '0;
      r_awaddr  <= '0;
      r_wstrb   <= '0;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_rready  <= 1'b1;
      r_bready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_write   <= i_req_write;
            r_signed  <= i_req_signed;
            r_addr_lo <= i_req_addr[1:0];
            r_size    <= i_req_size;
            r_err     <= w_misalign;
            r_resp    <= RESP_OKAY;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (w_misalign) begin
              r_state <= ST_DONE;
            end else if (i_req_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
              r_wdata   <= w_st_data;
              r_wstrb   <= {4'b0000, w_st_strb};
              r_state   <= ST_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_araddr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
              r_state   <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (i_mem_arready) begin
            r_arvalid <= 1'b0;
            // A responder may return data in the same cycle it accepts the address.
            if (i_mem_rvalid) begin
              r_rdata <= i_mem_rdata;
              r_resp  <= i_mem_rresp;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_RD_DATA;
            end
          end
        end
        ST_RD_DATA: begin
          if (i_mem_rvalid) begin
            r_rdata <= i_mem_rdata;
            r_resp  <= i_mem_rresp;
            r_state <= ST_DONE;
          end
        end
        ST_WR_REQ: begin
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done | w_aw_fire) && (r_w_done | w_w_fire)) begin
            r_state <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (i_mem_bvalid) begin
            r_resp  <= i_mem_bresp;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_timeout) begin
        r_arvalid <= 1'b0;
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_state   <= ST_DONE;
      end
    end
  end

  assign o_req_ready   = (r_state == ST_IDLE);
  assign o_resp_valid  = (r_state == ST_DONE);
  assign o_resp_err    = o_resp_valid & (r_err | (r_resp != RESP_OKAY) | w_tmo_flag);
  assign o_resp_rdata  = (o_resp_valid && !r_write && !w_tmo_flag) ? w_ld_data : '0;

  assign o_mem_arvalid = r_arvalid;
  assign o_mem_araddr  = r_araddr;
  assign o_mem_awvalid = r_awvalid;
  assign o_mem_awaddr  = r_awaddr;
  assign o_mem_wvalid  = r_wvalid;
  assign o_mem_wdata   = r_wdata;
  assign o_mem_wstrb   = r_wstrb;
  assign o_mem_rready  = r_rready;
  assign o_mem_bready  = r_bready;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master: directed scenarios plus randomized transactions.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_vec = 0;
  int n_fail = 0;

  // Observations from the most recent transaction.
  int          t_nar, t_naw, t_nw, t_nresp, t_lat;
  logic [31:0] t_araddr, t_awaddr, t_wdata, t_rdata;
  logic [7:0]  t_wstrb;
  logic        t_err, t_bad, t_rdy_after;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_write   (req_write),
    .i_req_addr    (req_addr),
    .i_req_size    (req_size),
    .i_req_signed  (req_signed),
    .i_req_wdata   (req_wdata),
    .o_resp_valid  (resp_valid),
    .o_resp_rdata  (resp_rdata),
    .o_resp_err    (resp_err),
    .o_mem_awvalid (awvalid),
    .i_mem_awready (awready),
    .o_mem_awaddr  (awaddr),
    .o_mem_wvalid  (wvalid),
    .i_mem_wready  (wready),
    .o_mem_wdata   (wdata),
    .o_mem_wstrb   (wstrb),
    .i_mem_bvalid  (bvalid),
    .o_mem_bready  (bready),
    .i_mem_bresp   (bresp),
    .o_mem_arvalid (arvalid),
    .i_mem_arready (arready),
    .o_mem_araddr  (araddr),
    .i_mem_rvalid  (rvalid),
    .o_mem_rready  (rready),
    .i_mem_rdata   (rdata),
    .i_mem_rresp   (rresp)
  );

  // Reference load result: shift, truncate to size, then extend.
  function automatic logic [31:0] m_load(logic [31:0] mw, int off, int nb, bit sgn);
    longint unsigned v, lim;
    lim = 64'd1 << (8 * nb);
    v = 64'(mw);
    v = (v >> (8 * off)) % lim;
    if (sgn && v >= (lim >> 1)) v = v + (64'd1 << 32) - lim;
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_addr = 0; req_size = 0; req_signed = 0; req_wdata = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
  endtask

  // Behavioural responder: one request, programmable per-channel wait cycles.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                         input bit sgn, input logic [31:0] wd, input logic [31:0] mw,
                         input logic [1:0] rsp, input int ar_d, input int r_d,
                         input int aw_d, input int w_d, input int b_d);
    int ar_c, aw_c, w_c, ar_hs, aw_hs, w_hs, b_at;
    bit ar_seen, aw_seen, w_seen;
    t_nar = 0; t_naw = 0; t_nw = 0; t_nresp = 0; t_lat = -1; t_bad = 0; t_rdy_after = 0;
    t_araddr = 0; t_awaddr = 0; t_wdata = 0; t_wstrb = 0; t_rdata = 0; t_err = 0;
    ar_c = ar_d; aw_c = aw_d; w_c = w_d; ar_hs = -1; aw_hs = -1; w_hs = -1;
    ar_seen = 0; aw_seen = 0; w_seen = 0;
    @(negedge clk);
    req_valid = 1; req_write = wr; req_addr = addr; req_size = sz;
    req_signed = sgn; req_wdata = wd;
    if (!req_ready) t_bad = 1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) req_valid = 0;
      if (resp_valid) begin
        t_nresp++;
        if (t_lat < 0) begin t_lat = cyc; t_rdata = resp_rdata; t_err = resp_err; end
      end
      if (cyc > 0 && (t_lat < 0 || cyc == t_lat) && req_ready) t_bad = 1;
      if (t_lat >= 0 && cyc == t_lat + 1) t_rdy_after = req_ready;
      if (!rready || !bready) t_bad = 1;
      arready = 0;
      if (arvalid) begin
        if (!ar_seen) begin ar_seen = 1; t_araddr = araddr; end
        else if (ar_hs < 0 && araddr !== t_araddr) t_bad = 1;
        if (ar_c == 0) begin arready = 1; t_nar++; if (ar_hs < 0) ar_hs = cyc; end
        else ar_c--;
      end else if (ar_seen && ar_hs < 0) t_bad = 1;
      rvalid = (ar_hs >= 0 && cyc == ar_hs + r_d);
      rdata  = rvalid ? mw : $urandom;
      rresp  = rvalid ? rsp : 2'b11;
      awready = 0;
      if (awvalid) begin
        if (!aw_seen) begin aw_seen = 1; t_awaddr = awaddr; end
        else if (aw_hs < 0 && awaddr !== t_awaddr) t_bad = 1;
        if (aw_c == 0) begin awready = 1; t_naw++; if (aw_hs < 0) aw_hs = cyc; end
        else aw_c--;
      end else if (aw_seen && aw_hs < 0) t_bad = 1;
      wready = 0;
      if (wvalid) begin
        if (!w_seen) begin w_seen = 1; t_wdata = wdata; t_wstrb = wstrb; end
        else if (w_hs < 0 && (wdata !== t_wdata || wstrb !== t_wstrb)) t_bad = 1;
        if (w_c == 0) begin wready = 1; t_nw++; if (w_hs < 0) w_hs = cyc; end
        else w_c--;
      end else if (w_seen && w_hs < 0) t_bad = 1;
      b_at = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + b_d;
      bvalid = (aw_hs >= 0 && w_hs >= 0 && cyc == b_at);
      bresp  = bvalid ? rsp : 2'b11;
      if (t_lat >= 0 && cyc == t_lat + 2) break;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    repeat (3) @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    n_vec++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valids got=%b exp=000", {arvalid, awvalid, wvalid}); end
    n_vec++; if ({rready, bready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_readys got=%b exp=11", {rready, bready}); end
    n_vec++; if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
      n_fail++; $display("FAIL reset_resp got=%b/%b/%h exp=0/0/0", resp_valid, resp_err, resp_rdata); end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_load_byte_signed();
    run_txn(0, 32'h8000_0003, 2'd0, 1, 32'h0, 32'h80FF_1234, 2'b00, 0, 1, 0, 0, 0);
    n_vec++; if (t_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL lbs_araddr got=%h exp=80000000", t_araddr); end
    n_vec++; if (t_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lbs_rdata got=%h exp=ffffff80", t_rdata); end
    n_vec++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL lbs_err got=%b exp=0", t_err); end
    n_vec++; if (t_lat != 3) begin n_fail++; $display("FAIL lbs_latency got=%0d exp=3", t_lat); end
    n_vec++; if (t_nar != 1 || t_bad !== 1'b0) begin n_fail++; $display("FAIL lbs_proto nar=%0d bad=%b exp=1/0", t_nar, t_bad); end
  endtask

  task automatic test_store_half();
    run_txn(1, 32'h8000_0002, 2'd1, 0, 32'h0000_BEEF, 32'h0, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (t_awaddr !== 32'h8000_0000) begin n_fail++; $display("FAIL sh_awaddr got=%h exp=80000000", t_awaddr); end
    n_vec++; if (t_wstrb !== 8'h0C) begin n_fail++; $display("FAIL sh_wstrb got=%h exp=0c", t_wstrb); end
    n_vec++; if (t_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata got=%h exp=beefbeef", t_wdata); end
    n_vec++; if (t_nresp != 1 || t_err !== 1'b0) begin
      n_fail++; $display("FAIL sh_resp pulses=%0d err=%b exp=1/0", t_nresp, t_err); end
  endtask

  task automatic test_misaligned();
    run_txn(0, 32'h8000_0001, 2'd2, 0, 32'h0, 32'h1234_5678, 2'b00, 0, 1, 0, 0, 0);
    n_vec++; if (t_nar != 0) begin n_fail++; $display("FAIL mis_no_ar got=%0d exp=0", t_nar); end
    n_vec++; if (t_lat != 1) begin n_fail++; $display("FAIL mis_latency got=%0d exp=1", t_lat); end
    n_vec++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got=%b exp=1", t_err); end
  endtask

  task automatic test_aw_before_w();
    logic [31:0] d;
    d = $urandom;
    run_txn(1, 32'h8000_0010, 2'd2, 0, d, 32'h0, 2'b00, 0, 0, 0, 3, 0);
    n_vec++; if (t_naw != 1 || t_nw != 1) begin
      n_fail++; $display("FAIL aw_w_counts aw=%0d w=%0d exp=1/1", t_naw, t_nw); end
    n_vec++; if (t_bad !== 1'b0) begin n_fail++; $display("FAIL aw_w_hold got=%b exp=0", t_bad); end
    n_vec++; if (t_wdata !== d || t_wstrb !== 8'h0F) begin
      n_fail++; $display("FAIL aw_w_data got=%h/%h exp=%h/0f", t_wdata, t_wstrb, d); end
    n_vec++; if (t_err !== 1'b0 || t_lat != 6) begin
      n_fail++; $display("FAIL aw_w_resp err=%b lat=%0d exp=0/6", t_err, t_lat); end
  endtask

  task automatic test_rresp_err();
    logic [31:0] m;
    m = $urandom;
    run_txn(0, 32'h8000_0004, 2'd2, 0, 32'h0, m, 2'b10, 1, 2, 0, 0, 0);
    n_vec++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL rerr_err got=%b exp=1", t_err); end
    n_vec++; if (t_rdata !== m) begin n_fail++; $display("FAIL rerr_rdata got=%h exp=%h", t_rdata, m); end
    n_vec++; if (t_rdy_after !== 1'b1) begin n_fail++; $display("FAIL rerr_ready got=%b exp=1", t_rdy_after); end
  endtask

  task automatic test_reset_mid_read();
    int late;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 32'h8000_0020; req_size = 2'd2;
    @(negedge clk);
    req_valid = 0;
    n_vec++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ar got=%b exp=1", arvalid); end
    arready = 1;
    @(negedge clk);
    arready = 0;
    n_vec++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ar_drop got=%b exp=0", arvalid); end
    rst = 0;
    @(negedge clk);
    rst = 1;
    n_vec++; if ({arvalid, awvalid, wvalid, req_ready, resp_valid} !== 5'b00010) begin
      n_fail++; $display("FAIL rst_mid_state got=%b exp=00010", {arvalid, awvalid, wvalid, req_ready, resp_valid}); end
    rvalid = 1; rdata = $urandom; rresp = 2'b00;
    late = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rvalid = 0;
      if (resp_valid) late++;
    end
    n_vec++; if (late != 0) begin n_fail++; $display("FAIL rst_mid_late_r got=%0d pulses exp=0", late); end
  endtask

  task automatic test_random();
    bit wr, sgn, bad;
    logic [1:0] sz, rsp;
    logic [31:0] addr, wd, mw, e_wd;
    logic [7:0] e_strb;
    int nb, off, ad, rd, awd, wdl, bd, e_lat;
    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      wd = $urandom; mw = $urandom;
      rsp = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
      ad = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      awd = $urandom_range(0, 3); wdl = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      run_txn(wr, addr, sz, sgn, wd, mw, rsp, ad, rd, awd, wdl, bd);
      nb = 1 << sz; off = addr % 4;
      bad = (sz == 2'd3) || (addr % nb != 0);
      e_lat = bad ? 1 : (wr ? (((awd > wdl) ? awd : wdl) + 3 + bd) : (2 + ad + rd));
      e_strb = 8'(((1 << nb) - 1) << off);
      case (sz)
        2'd0: e_wd = 32'(wd[7:0]) * 32'h0101_0101;
        2'd1: e_wd = 32'(wd[15:0]) * 32'h0001_0001;
        default: e_wd = wd;
      endcase
      n_vec++; if (t_nresp != 1 || t_lat != e_lat) begin n_fail++;
        $display("FAIL rnd%0d_timing pulses=%0d lat=%0d exp=1/%0d", k, t_nresp, t_lat, e_lat); end
      n_vec++; if (t_err !== (bad | (rsp != 2'b00))) begin n_fail++;
        $display("FAIL rnd%0d_err got=%b exp=%b", k, t_err, bad | (rsp != 2'b00)); end
      n_vec++; if (t_bad !== 1'b0 || t_rdy_after !== 1'b1) begin n_fail++;
        $display("FAIL rnd%0d_proto bad=%b rdy=%b exp=0/1", k, t_bad, t_rdy_after); end
      n_vec++; if (t_nar != int'(!wr && !bad) || t_naw != int'(wr && !bad) || t_nw != t_naw) begin
        n_fail++; $display("FAIL rnd%0d_bus ar=%0d aw=%0d w=%0d wr=%b bad=%b", k, t_nar, t_naw, t_nw, wr, bad); end
      if (!bad && !wr) begin
        n_vec++; if (t_araddr !== (addr & ~32'h3)) begin n_fail++;
          $display("FAIL rnd%0d_araddr got=%h exp=%h", k, t_araddr, addr & ~32'h3); end
        n_vec++; if (t_rdata !== m_load(mw, off, nb, sgn)) begin n_fail++;
          $display("FAIL rnd%0d_rdata got=%h exp=%h", k, t_rdata, m_load(mw, off, nb, sgn)); end
      end
      if (!bad && wr) begin
        n_vec++; if (t_awaddr !== (addr & ~32'h3)) begin n_fail++;
          $display("FAIL rnd%0d_awaddr got=%h exp=%h", k, t_awaddr, addr & ~32'h3); end
        n_vec++; if (t_wdata !== e_wd || t_wstrb !== e_strb) begin n_fail++;
          $display("FAIL rnd%0d_wdata got=%h/%h exp=%h/%h", k, t_wdata, t_wstrb, e_wd, e_strb); end
        n_vec++; if (t_rdata !== 32'h0) begin n_fail++;
          $display("FAIL rnd%0d_store_rdata got=%h exp=0", k, t_rdata); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_byte_signed();
    test_store_half();
    test_misaligned();
    test_aw_before_w();
    test_rresp_err();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
